// File: rtl/alu_seq.sv
// Execute-stage ALU: one op at a time over valid/ready, registered result + NZCV.
// Latency: single-cycle ops registered on the accept edge; MUL adds WIDTH iterations.
// Backpressure: result holds in DONE until out_ready; no new op accepted meanwhile.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic             is_mul;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;

  // Carry-out comes from the extra top bit; SUB is A + ~B + 1 so carry means no borrow.
  assign add_full  = {1'b0, SrcA} + {1'b0, SrcB};
  assign sub_full  = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt     = SrcB[SHW-1:0];
  assign is_mul    = (ALUControl == OP_MUL) && MUL_EN;
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Single-cycle result and arithmetic flags computed straight from the live inputs.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (ALUControl)
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_full[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = sub_full[WIDTH];
        sc_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_full[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:  sc_res = SrcA << shamt;
      OP_SRL:  sc_res = SrcA >> shamt;
      OP_SRA:  sc_res = $signed(SrcA) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: MUL iterates WIDTH times, DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (last_iter) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake signals are pure functions of the state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state: capture on accept, shift-add per MUL cycle, hold in DONE.
  always_comb begin
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            mcand_d  = SrcA;
            mplier_d = SrcB;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            res_d = sc_res;
            z_d   = (sc_res == '0);
            n_d   = sc_res[WIDTH-1];
            c_d   = sc_c;
            v_d   = sc_v;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // The final iteration's sum is the product; register it directly.
        if (last_iter) begin
          res_d = acc_step;
          z_d   = (acc_step == '0);
          n_d   = acc_step[WIDTH-1];
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset so an aborted op leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALUResult = res_q;
  assign Zero      = z_q;
  assign Negative  = n_q;
  assign Carry     = c_q;
  assign Overflow  = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8-bit, 32-bit and 8-bit no-MUL instances on one clock.
// Directed cases plus random ops compared against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  iv, ordy;
  logic [31:0] sa [3];
  logic [31:0] sb [3];
  logic [3:0]  opc [3];
  wire  [2:0]  ir, ov, zf, nf, cf, vf;
  wire  [7:0]  r0, r2;
  wire  [31:0] r1;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .SrcA(sa[0][7:0]), .SrcB(sb[0][7:0]), .ALUControl(opc[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .ALUResult(r0),
    .Zero(zf[0]), .Negative(nf[0]), .Carry(cf[0]), .Overflow(vf[0]));

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .SrcA(sa[1]), .SrcB(sb[1]), .ALUControl(opc[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .ALUResult(r1),
    .Zero(zf[1]), .Negative(nf[1]), .Carry(cf[1]), .Overflow(vf[1]));

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .SrcA(sa[2][7:0]), .SrcB(sb[2][7:0]), .ALUControl(opc[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .ALUResult(r2),
    .Zero(zf[2]), .Negative(nf[2]), .Carry(cf[2]), .Overflow(vf[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int d);
    return (d == 1) ? 32 : 8;
  endfunction

  function automatic bit mul_en(input int d);
    return d != 2;
  endfunction

  function automatic logic [31:0] res_of(input int d);
    if (d == 0) return {24'd0, r0};
    if (d == 1) return r1;
    return {24'd0, r2};
  endfunction

  function automatic logic [3:0] flags_of(input int d);
    return {vf[d], cf[d], nf[d], zf[d]};
  endfunction

  // Reference: {V,C,N,Z,result[31:0]} from plain integer arithmetic on w-bit values.
  function automatic logic [35:0] model(input int w, input bit me, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, s, r;
    longint          sa_, sb_, t, lim;
    int              sh;
    bit              c, v;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa_  = longint'(ua);
    if (ua[w-1]) sa_ = sa_ - longint'(mask) - 64'sd1;
    sb_  = longint'(ub);
    if (ub[w-1]) sb_ = sb_ - longint'(mask) - 64'sd1;
    lim  = longint'(64'd1 << (w - 1));
    sh   = int'(ub[4:0]) & (w - 1);
    r = 64'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = ua + ub; r = s & mask; c = s[w]; t = sa_ + sb_; v = (t >= lim) || (t < -lim); end
      4'd1: begin s = ua + ((~ub) & mask) + 64'd1; r = s & mask; c = s[w]; t = sa_ - sb_; v = (t >= lim) || (t < -lim); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (sa_ < sb_) ? 64'd1 : 64'd0;
      4'd6: r = (ua < ub) ? 64'd1 : 64'd0;
      4'd7: r = (ua << sh) & mask;
      4'd8: r = ua >> sh;
      4'd9: r = $unsigned(sa_ >>> sh) & mask;
      4'd10: r = me ? ((ua * ub) & mask) : 64'd0;
      default: r = 64'd0;
    endcase
    return {v, c, r[w-1], (r == 64'd0), r[31:0]};
  endfunction

  // Issue one op on instance d, measure latency, optionally stall in DONE, then consume.
  task automatic run_op(input int d, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [35:0] exp;
    int          lat, exp_lat;
    bit          irbad, unstable;
    logic [31:0] r_snap;
    logic [3:0]  f_snap;
    string       pfx;
    pfx     = $sformatf("d%0d op%0h a=%0h b=%0h", d, o, a, b);
    exp     = model(wid(d), mul_en(d), o, a, b);
    exp_lat = (o == 4'hA && mul_en(d)) ? wid(d) + 1 : 1;
    @(negedge clk);
    check({pfx, " idle_ready"}, 64'(ir[d]), 64'd1);
    iv[d] = 1'b1; sa[d] = a; sb[d] = b; opc[d] = o;
    @(posedge clk); #1;
    iv[d] = 1'b0; sa[d] = $urandom; sb[d] = $urandom; opc[d] = 4'($urandom);
    lat = 1; irbad = 1'b0;
    while (!ov[d] && lat < 100) begin
      if (ir[d]) irbad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({pfx, " latency"}, 64'(lat), 64'(exp_lat));
    check({pfx, " busy_ready_low"}, 64'(irbad), 64'd0);
    r_snap = res_of(d); f_snap = flags_of(d); unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv[d] = 1'($urandom); sa[d] = $urandom; opc[d] = 4'($urandom);
      @(posedge clk); #1;
      if (res_of(d) !== r_snap || flags_of(d) !== f_snap || !ov[d] || ir[d]) unstable = 1'b1;
    end
    if (hold > 0) check({pfx, " hold_stable"}, 64'(unstable), 64'd0);
    check({pfx, " result"}, 64'(res_of(d)), 64'(exp[31:0]));
    check({pfx, " flags_vcnz"}, 64'(flags_of(d)), 64'(exp[35:32]));
    @(negedge clk);
    iv[d] = 1'b0; ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    check({pfx, " consumed_ov_ir"}, 64'({ov[d], ir[d]}), 64'b01);
  endtask

  initial begin
    reset = 1'b1; iv = 3'b000; ordy = 3'b000;
    for (int i = 0; i < 3; i++) begin sa[i] = '0; sb[i] = '0; opc[i] = '0; end
    #13;
    check("reset out_valid", 64'(ov), 64'd0);
    check("reset in_ready", 64'(ir), 64'b111);
    check("reset result", 64'({r0, r1, r2}), 64'd0);
    check("reset flags", 64'({zf, nf, cf, vf}), 64'd0);
    @(negedge clk); reset = 1'b0;

    // ADD wrap, SUB overflow/borrow, MUL at both widths and with MUL disabled.
    run_op(0, 4'h0, 32'hFF, 32'h01, 0);
    run_op(1, 4'h0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(0, 4'h1, 32'h80, 32'h01, 0);
    run_op(0, 4'h1, 32'h01, 32'h02, 0);
    run_op(1, 4'h1, 32'h8000_0000, 32'h1, 0);
    run_op(0, 4'hA, 32'h0D, 32'h0B, 0);
    run_op(1, 4'hA, 32'h0001_2345, 32'h0000_BEEF, 0);
    run_op(2, 4'hA, 32'h0D, 32'h0B, 0);
    // Stall in DONE with a noisy source.
    run_op(0, 4'h0, 32'h12, 32'h34, 5);
    run_op(0, 4'hA, 32'hFF, 32'hFF, 3);
    // Shifts, compares, unsupported opcode.
    run_op(0, 4'h9, 32'h90, 32'h03, 0);
    run_op(0, 4'h8, 32'h90, 32'h03, 0);
    run_op(0, 4'h7, 32'h90, 32'h0B, 0);
    run_op(0, 4'h5, 32'hFF, 32'h01, 0);
    run_op(0, 4'h6, 32'hFF, 32'h01, 0);
    run_op(0, 4'hF, 32'hFF, 32'h01, 0);

    // Reset in the fourth MUL cycle aborts the op.
    @(negedge clk);
    iv[0] = 1'b1; sa[0] = 32'h0D; sb[0] = 32'h0B; opc[0] = 4'hA;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset mid-mul out_valid", 64'(ov[0]), 64'd0);
    check("reset mid-mul in_ready", 64'(ir[0]), 64'd1);
    check("reset mid-mul result", 64'(r0), 64'd0);
    @(negedge clk); reset = 1'b0;
    run_op(0, 4'h0, 32'h03, 32'h04, 0);

    // Reset while a result waits in DONE drops out_valid without a clock edge.
    @(negedge clk);
    iv[0] = 1'b1; sa[0] = 32'h05; sb[0] = 32'h06; opc[0] = 4'h0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("pre-reset done out_valid", 64'(ov[0]), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("reset mid-done out_valid", 64'(ov[0]), 64'd0);
    check("reset mid-done result", 64'(r0), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Random ops across all three instances.
    for (int i = 0; i < 90; i++) begin
      int d;
      d = $urandom_range(0, 2);
      run_op(d, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
